// File: rtl/voice_allocator.sv
// voice_allocator: maps up to KEYS key states onto VOICES VCO channels and
// issues DAC commands (voice address + tuned code) over a valid/ready handshake.
// Keys that cannot get a voice stay pending and are re-assigned when a voice
// is released. Optional build macro VOICE_ALLOC_STEAL_EN: a note-on with no
// free voice steals the oldest voice (the robbed key becomes pending).
module voice_allocator #(
    parameter int unsigned VOICES    = 5,
    parameter int unsigned KEYS      = 32,
    parameter int unsigned NOTE_BITS = 7,
    parameter int unsigned DAC_BITS  = 12,
    parameter int unsigned ADDR_BITS = 3,
    localparam int unsigned KEY_BITS = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic [NOTE_BITS-1:0] ev_note,
    input  logic                 ev_on,
    input  logic [DAC_BITS-1:0]  tune,
    output logic [KEY_BITS-1:0]  key_idx,
    input  logic [DAC_BITS-1:0]  key_code,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ADDR_BITS-1:0] cmd_voice,
    output logic [DAC_BITS-1:0]  cmd_value,
    output logic [VOICES-1:0]    voice_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ISSUE  = 2'd2,
        RESCAN = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_hold;       // accepted event waiting for its mapping decision
    logic [KEY_BITS-1:0]  r_ev_key;
    logic                 r_ev_on;
    logic                 r_release;    // current command is a mute; rescan afterwards
    logic [KEY_BITS-1:0]  r_tgt_key;
    logic [ADDR_BITS-1:0] r_tgt_voice;
    logic [KEYS-1:0]      r_keys;
    logic [KEYS-1:0]      r_mapped;
    logic [ADDR_BITS-1:0] r_key_voice [KEYS];

    logic                 r_ev_ready;
    logic [KEY_BITS-1:0]  r_key_idx;
    logic                 r_cmd_valid;
    logic [ADDR_BITS-1:0] r_cmd_voice;
    logic [DAC_BITS-1:0]  r_cmd_value;
    logic [VOICES-1:0]    r_voice_active;

    logic                 w_note_ok;
    logic [KEY_BITS-1:0]  w_ev_key;
    logic                 w_free_found;
    logic [ADDR_BITS-1:0] w_free_idx;
    logic [KEYS-1:0]      w_pend;
    logic                 w_pend_found;
    logic [KEY_BITS-1:0]  w_pend_idx;
    logic [DAC_BITS:0]    w_diff;
    logic [DAC_BITS-1:0]  w_tuned;

    assign ev_ready     = r_ev_ready;
    assign key_idx      = r_key_idx;
    assign cmd_valid    = r_cmd_valid;
    assign cmd_voice    = r_cmd_voice;
    assign cmd_value    = r_cmd_value;
    assign voice_active = r_voice_active;

    assign w_note_ok = (32'(ev_note) < KEYS);
    assign w_ev_key  = KEY_BITS'(ev_note);
    assign w_pend    = r_keys & ~r_mapped;

    // Tuned code: one extra bit catches borrow so the result clamps at zero
    assign w_diff  = {1'b0, key_code} - {1'b0, tune};
    assign w_tuned = w_diff[DAC_BITS] ? '0 : w_diff[DAC_BITS-1:0];

    // Lowest-index free voice
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = int'(VOICES) - 1; i >= 0; i--) begin
            if (!r_voice_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = ADDR_BITS'(i);
            end
        end
    end

    // Lowest-index key that is pressed but has no voice
    always_comb begin
        w_pend_found = 1'b0;
        w_pend_idx   = '0;
        for (int i = int'(KEYS) - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_pend_found = 1'b1;
                w_pend_idx   = KEY_BITS'(i);
            end
        end
    end

`ifdef VOICE_ALLOC_STEAL_EN
    localparam int unsigned AGE_BITS = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(VOICES - 1);

    logic [AGE_BITS-1:0]  r_age       [VOICES];
    logic [KEY_BITS-1:0]  r_voice_key [VOICES];
    logic [ADDR_BITS-1:0] w_old_idx;
    logic [AGE_BITS-1:0]  w_old_age;

    // Oldest voice; strict compare keeps the lowest index on ties
    always_comb begin
        w_old_idx = '0;
        w_old_age = r_age[0];
        for (int i = 1; i < int'(VOICES); i++) begin
            if (r_age[i] > w_old_age) begin
                w_old_idx = ADDR_BITS'(i);
                w_old_age = r_age[i];
            end
        end
    end

    // Voice ownership and ages, updated on every assignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(VOICES); i++) begin
                r_age[i]       <= '0;
                r_voice_key[i] <= '0;
            end
        end else if (r_state == LOOKUP) begin
            r_voice_key[r_tgt_voice] <= r_tgt_key;
            for (int i = 0; i < int'(VOICES); i++) begin
                if (ADDR_BITS'(i) == r_tgt_voice) begin
                    r_age[i] <= '0;
                end else if (r_voice_active[i] && (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end
`endif

    // Allocation FSM with registered handshake and command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_hold         <= 1'b0;
            r_ev_key       <= '0;
            r_ev_on        <= 1'b0;
            r_release      <= 1'b0;
            r_tgt_key      <= '0;
            r_tgt_voice    <= '0;
            r_keys         <= '0;
            r_mapped       <= '0;
            r_ev_ready     <= 1'b0;
            r_key_idx      <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_voice    <= '0;
            r_cmd_value    <= '0;
            r_voice_active <= '0;
            for (int i = 0; i < int'(KEYS); i++) begin
                r_key_voice[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_hold) begin
                        r_hold <= 1'b0;
                        if (r_ev_on) begin
                            if (r_mapped[r_ev_key]) begin
                                r_ev_ready <= 1'b1;
                            end else if (w_free_found) begin
                                r_tgt_key   <= r_ev_key;
                                r_tgt_voice <= w_free_idx;
                                r_key_idx   <= r_ev_key;
                                r_state     <= LOOKUP;
                            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                                r_mapped[r_voice_key[w_old_idx]] <= 1'b0;
                                r_tgt_key   <= r_ev_key;
                                r_tgt_voice <= w_old_idx;
                                r_key_idx   <= r_ev_key;
                                r_state     <= LOOKUP;
`else
                                r_ev_ready  <= 1'b1;
`endif
                            end
                        end else if (r_mapped[r_ev_key]) begin
                            r_mapped[r_ev_key]                       <= 1'b0;
                            r_voice_active[r_key_voice[r_ev_key]]    <= 1'b0;
                            r_tgt_voice                              <= r_key_voice[r_ev_key];
                            r_cmd_voice                              <= r_key_voice[r_ev_key];
                            r_cmd_value                              <= '1;
                            r_cmd_valid                              <= 1'b1;
                            r_release                                <= 1'b1;
                            r_state                                  <= ISSUE;
                        end else begin
                            r_ev_ready <= 1'b1;
                        end
                    end else begin
                        r_ev_ready <= 1'b1;
                        if (ev_valid && r_ev_ready && w_note_ok) begin
                            r_keys[w_ev_key] <= ev_on;
                            r_ev_key         <= w_ev_key;
                            r_ev_on          <= ev_on;
                            r_hold           <= 1'b1;
                            r_ev_ready       <= 1'b0;
                        end
                    end
                end

                LOOKUP: begin
                    r_cmd_voice                 <= r_tgt_voice;
                    r_cmd_value                 <= w_tuned;
                    r_cmd_valid                 <= 1'b1;
                    r_mapped[r_tgt_key]         <= 1'b1;
                    r_key_voice[r_tgt_key]      <= r_tgt_voice;
                    r_voice_active[r_tgt_voice] <= 1'b1;
                    r_state                     <= ISSUE;
                end

                ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        if (r_release) begin
                            r_state <= RESCAN;
                        end else begin
                            r_ev_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end

                RESCAN: begin
                    r_release <= 1'b0;
                    if (w_pend_found) begin
                        r_tgt_key <= w_pend_idx;
                        r_key_idx <= w_pend_idx;
                        r_state   <= LOOKUP;
                    end else begin
                        r_ev_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Parametrised polyphonic voice allocator. It sits between the MIDI receiver and the DAC driver, and maps up to KEYS key states onto VOICES VCO channels. For each mapping change it issues DAC commands (voice address plus tuned control value) over a valid/ready handshake. Unlike the first-generation allocator, it re-assigns waiting keys when a voice frees up, and it can optionally steal the oldest voice.

## Interface
- VOICES, 5, number of VCO channels (1..8)
- KEYS, 32, number of tracked keys; notes >= KEYS are ignored
- NOTE_BITS, 7, width of MIDI note number
- DAC_BITS, 12, DAC code width
- ADDR_BITS, 3, DAC channel address width (2**ADDR_BITS >= VOICES)
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- ev_valid  in  1  MIDI note event present
- ev_ready  out  1  allocator can accept an event
- ev_note  in  NOTE_BITS  note number
- ev_on  in  1  1 = key down, 0 = key up
- tune  in  DAC_BITS  frequency-adjust offset (ADC reading)
- key_idx  out  $clog2(KEYS)  key index presented to the external key→code ROM
- key_code  in  DAC_BITS  combinational ROM result for key_idx
- cmd_valid  out  1  DAC command pending
- cmd_ready  in  1  DAC driver accepts command
- cmd_voice  out  ADDR_BITS  voice/DAC channel
- cmd_value  out  DAC_BITS  DAC code
- voice_active  out  VOICES  per-voice enable bitmap

## Operation
- State: keys[KEYS], mapped[KEYS], key_voice[KEYS], voice_key[VOICES], voice_active, age[VOICES].
- FSM states: IDLE, LOOKUP, ISSUE, RESCAN.
- **IDLE**: ev_ready=1. An event is accepted on ev_valid&&ev_ready.
  - ev_note >= KEYS: the event is dropped and the FSM stays in IDLE.
  - Otherwise keys[note] is set to ev_on.
- **Note-on**:
  - If the key is already mapped, or no voice can be obtained, there is no command and the FSM returns to IDLE. The key stays pending.
  - Otherwise the FSM takes the lowest-index free voice and goes to LOOKUP.
- **Note-off**:
  - Unmapped key: returns to IDLE.
  - Mapped key: cmd_value = all-ones (mute), voice freed, then ISSUE; after the handshake the FSM goes to RESCAN.
- **LOOKUP**:
  - key_idx = target key.
  - Registers cmd_value = max(key_code − tune, 0). The subtraction is DAC_BITS+1 wide and saturates at 0, with no wrap-around.
  - Sets mapping and voice_active, then goes to ISSUE.
- **ISSUE**: cmd_valid=1 with cmd_voice/cmd_value stable until cmd_ready. Then the FSM goes to IDLE, or to RESCAN after a release.
- **RESCAN**: if any key is pressed and unmapped, the lowest-index such key is assigned to the just-freed voice via LOOKUP. Otherwise the FSM goes to IDLE.
- **Age**: on assignment, the assigned voice's age is set to 0 and all other active voices' ages increment, saturating at VOICES−1.
- key_idx holds its last value outside LOOKUP.

## Timing
- **Reset values** (asynchronous, while rst_n=0): ev_ready=0, cmd_valid=0, cmd_voice=0, cmd_value=0, voice_active=0, key_idx=0. All maps and ages are cleared and the FSM enters IDLE. ev_ready=1 from the first clk edge after rst_n deasserts.
- **Reset mid-operation**: an in-flight command is abandoned and cmd_valid drops immediately. No mute command is generated.
- **Note-on latency**: event accepted at edge T → LOOKUP during T+1 → cmd_valid asserted after edge T+2. voice_active updates at edge T+2.
- **Note-off latency**: cmd_valid asserted after edge T+1.
- **Throughput**: ev_ready is low from T+1 until the FSM returns to IDLE. A release followed by a reassignment needs two handshakes.
- **Command handshake**: transfer occurs on an edge where cmd_valid&&cmd_ready. The command may be accepted the same cycle it is asserted. cmd_valid deasserts the cycle after transfer unless a new command follows.
- tune is sampled only in LOOKUP.

## Configuration
- VOICE_ALLOC_STEAL_EN **defined**: a note-on with no free voice steals the voice with the highest age (lowest index on ties).
  - The old key is unmapped but stays pressed, so it is pending.
  - The new key is assigned via LOOKUP with one command to that voice. No mute is issued in between.
- VOICE_ALLOC_STEAL_EN **undefined**: a note-on with no free voice issues no command. The key waits for RESCAN. Age logic may be omitted.

## Test plan
- **Basic on/off**: reset, cmd_ready=1, tune=0, key_code=2048. Note-on 5 → one command voice 0, value 2048, voice_active=5'b00001. Note-off 5 → voice 0, value 12'hFFF, voice_active=0.
- **Saturation**: key_code=100, tune=300 → cmd_value=0. key_code=1261, tune=16 → 1245.
- **Pending reassignment** (steal undefined): notes 0–5 on → voices 0–4 assigned, note 5 gets no command. Note 2 off → mute on voice 2, then note 5 assigned to voice 2.
- **Stealing** (VOICE_ALLOC_STEAL_EN defined): notes 0–4 on, then note 9 on → single command to voice 0 (oldest), note 0 pending. Note 9 off → mute voice 0, then note 0 reassigned to voice 0.
- **Backpressure and reset**:
  - Hold cmd_ready=0 for 10 cycles → cmd_value/voice stable and ev_ready=0 throughout.
  - Assert rst_n=0 mid-hold → cmd_valid=0 with no clock edge required.
  - Note 40 → accepted, no command.
